// File: rtl/keyboard_scanner.sv
// keyboard_scanner: maps NUM_KEYS raw board buttons to 16-bit Hack keycodes
// for the memory-mapped KBD register.
// Per-button path: two-flop synchroniser -> counter debounce -> priority
// encoder (highest index wins) -> registered keycode plus a one-cycle
// new-key strobe.
// Optional auto-repeat of key_valid is built only when KEYBOARD_REPEAT_EN
// is defined (adds REPEAT_DELAY / REPEAT_PERIOD parameters).
module keyboard_scanner #(
    parameter int                      NUM_KEYS        = 3,
    parameter int                      DEBOUNCE_CYCLES = 65536,
    parameter int                      CNT_W           = 17,
    parameter logic [NUM_KEYS*16-1:0]  KEYCODES        = {16'd130, 16'd140, 16'd132}
`ifdef KEYBOARD_REPEAT_EN
    ,
    parameter int                      REPEAT_DELAY    = 25_000_000,
    parameter int                      REPEAT_PERIOD   = 2_500_000
`endif
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic [NUM_KEYS-1:0] buttons,
    output logic [15:0]         out,
    output logic                key_valid,
    output logic [NUM_KEYS-1:0] pressed
);

    localparam int unsigned      NK      = NUM_KEYS;
    // Counter value on which the next disagreeing cycle completes the debounce.
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [NUM_KEYS-1:0]            sync1_q;
    logic [NUM_KEYS-1:0]            sync2_q;
    logic [NUM_KEYS-1:0]            pressed_q;
    logic [NUM_KEYS-1:0]            pressed_d;
    logic [NUM_KEYS-1:0][CNT_W-1:0] cnt_q;
    logic [NUM_KEYS-1:0][CNT_W-1:0] cnt_d;
    logic [15:0]                    out_q;
    logic [15:0]                    code_d;
    logic                           key_valid_q;
    logic                           key_valid_d;
    logic                           new_code;
    logic                           rpt_fire;

    // Two-stage synchroniser for the asynchronous button levels.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= buttons;
            sync2_q <= sync1_q;
        end
    end

    // Per-button debounce: count consecutive disagreeing cycles, flip on the last one.
    always_comb begin
        pressed_d = pressed_q;
        cnt_d     = '0;
        for (int unsigned i = 0; i < NK; i++) begin
            if (sync2_q[i] != pressed_q[i]) begin
                if (cnt_q[i] == DB_LAST) begin
                    pressed_d[i] = ~pressed_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    // Debounced state and counters; reset discards any partial count.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            pressed_q <= '0;
            cnt_q     <= '0;
        end else begin
            pressed_q <= pressed_d;
            cnt_q     <= cnt_d;
        end
    end

    // Priority encoder: later (higher) indices overwrite, zero-code entries are skipped.
    always_comb begin
        code_d = '0;
        for (int unsigned i = 0; i < NK; i++) begin
            if (pressed_q[i] && (KEYCODES[16*i +: 16] != 16'd0)) begin
                code_d = KEYCODES[16*i +: 16];
            end
        end
    end

    // A new nonzero code different from the current one is a fresh key event.
    always_comb begin
        new_code    = (code_d != 16'd0) && (code_d != out_q);
        key_valid_d = new_code | rpt_fire;
    end

`ifdef KEYBOARD_REPEAT_EN
    localparam logic [31:0] RPT_DELAY_LAST  = 32'(REPEAT_DELAY - 1);
    localparam logic [31:0] RPT_PERIOD_LAST = 32'(REPEAT_PERIOD - 1);

    logic [31:0] rpt_cnt_q;
    logic [31:0] rpt_cnt_d;
    logic        rpt_first_q;
    logic        rpt_first_d;
    logic        hold;

    // Repeat timer: restarts on any change of out; first interval is the delay, then the period.
    always_comb begin
        hold        = (code_d != 16'd0) && (code_d == out_q);
        rpt_cnt_d   = '0;
        rpt_first_d = 1'b1;
        rpt_fire    = 1'b0;
        if (hold) begin
            if (rpt_cnt_q == (rpt_first_q ? RPT_DELAY_LAST : RPT_PERIOD_LAST)) begin
                rpt_fire    = 1'b1;
                rpt_first_d = 1'b0;
            end else begin
                rpt_cnt_d   = rpt_cnt_q + 32'd1;
                rpt_first_d = rpt_first_q;
            end
        end
    end

    // Repeat timer state.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            rpt_cnt_q   <= '0;
            rpt_first_q <= 1'b1;
        end else begin
            rpt_cnt_q   <= rpt_cnt_d;
            rpt_first_q <= rpt_first_d;
        end
    end
`else
    // Without auto-repeat the strobe only reports new codes.
    always_comb begin
        rpt_fire = 1'b0;
    end
`endif

    // Registered keycode and strobe.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            out_q       <= '0;
            key_valid_q <= 1'b0;
        end else begin
            out_q       <= code_d;
            key_valid_q <= key_valid_d;
        end
    end

    assign out       = out_q;
    assign key_valid = key_valid_q;
    assign pressed   = pressed_q;

endmodule
